wm8731_i2c_responder: RTL and testbench
=======================================

// Module: wm8731_i2c_responder
// PURPOSE
//  Synthesizable I2C write-only responder modelling the WM8731 control port: the far end of codec_configurator.
//  Decodes 3-byte writes {dev_addr+W, reg[6:0]+data[8], data[7:0]}, ACKs them and updates a 9-bit register file.
//  Also exposes register values and a write strobe, so the configurator is checked closed-loop in sim/on-board.
// PARAMETERS
//  DEV_ADDR     7'h1A  7-bit device address (CSB=0); byte on wire 0x34
//  SYNC_STAGES  2      synchronizer flops on scl_in/sda_in (>=2)
// PORTS
//  clk          in   1  system clock; must be >=8x SCL rate
//  rst          in   1  reset, asynchronous, active-high
//  scl_in       in   1  I2C clock from bus (async)
//  sda_in       in   1  I2C data from bus (async)
//  sda_oe       out  1  1 = pull SDA low (open-drain); 0 = release
//  reg_wr       out  1  one-clk pulse: register write committed
//  reg_wr_addr  out  7  register address of committed write
//  reg_wr_data  out  9  data of committed write
//  rd_addr      in   4  combinational read select (0..9)
//  rd_data      out  9  regfile[rd_addr]; 0 for rd_addr>9
//  codec_active out  1  R9[0]
//  busy         out  1  1 between START and STOP
//  err_cnt      out  8  protocol error count (only with I2C_RESP_ERR_CNT_EN)
// BEHAVIOUR
//  - Reset: sda_oe=0, reg_wr=0, reg_wr_addr=0, reg_wr_data=0, busy=0, err_cnt=0, state IDLE.
//  - Reset regfile: R0=R1=0x097, R2=R3=0x079, R4=0x00A, R5=0x008, R6=0x09F, R7=0x00A, R8=R9=0x000.
//  - Inputs pass SYNC_STAGES flops; edges are detected on the synced signals.
//  - START = SDA fall while SCL high; STOP = SDA rise while SCL high.
//  - Bits are sampled on SCL rise, MSB first.
//  - FSM: IDLE -> (START) ADDR -> ACK0 -> HI -> ACK1 -> LO -> ACK2 -> IGNORE.
//  - ACK: sda_oe rises on the clk after the SCL fall that ends bit 8 and falls on the SCL fall that ends bit 9.
//  - ADDR: if byte == {DEV_ADDR,0}, ACK and go to HI. Otherwise (wrong address or R/W=1) NACK (sda_oe stays 0) and go to IGNORE.
//  - HI: latch addr=byte[7:1], d8=byte[0]; ACK.
//  - LO: ACK always. reg_wr pulses 1 clk after the 8th LO bit is sampled, only if addr<=9 or addr==15.
//      addr 0..9 updates the regfile on the same clk as reg_wr.
//      addr 15 (reset register) restores all regfile defaults; reg_wr still pulses with addr 15.
//      addr 10..14, 16..127: ACKed, no write, no pulse, counted as error.
//  - IGNORE: all further bytes are NACKed until STOP or a repeated START.
//  - Repeated START in any state -> ADDR; any partial word is discarded; sda_oe released.
//  - STOP in any state -> IDLE, sda_oe=0, busy=0. STOP before LO completes: no write.
//  - START and STOP are never simultaneous: at most one SDA edge per clk on the synced signal.
//  - Async reset mid-transfer: sda_oe drops immediately; the regfile returns to defaults.
//  - busy: set on the clk START is detected; cleared on the clk STOP is detected.
// CONFIGURATION
//  I2C_RESP_ERR_CNT_EN defined: err_cnt is an 8-bit counter saturating at 255.
//    +1 for: NACKed address byte; STOP or repeated START after ACK0 and before LO completes; out-of-range reg address.
//  Not defined: err_cnt tied to 8'h00; no counter logic.
// TESTING
//  1 Send 0x34,0x04,0x7F,STOP -> three ACKs; reg_wr pulse addr=2 data=0x07F; rd_addr=2 reads 0x07F.
//  2 Send 0x36,0x04,0x7F -> address NACK, byte 2 NACK, no reg_wr; err_cnt=1 (with EN).
//  3 Send 0x34,0x12,0x01,STOP -> codec_active=1. Then send 0x34,0x1E,0x00 -> codec_active=0, R0 reads 0x097, R6 reads 0x09F.
//  4 Send 0x34,0x0C then STOP -> no reg_wr; busy=0; err_cnt+1 (with EN); R6 unchanged.
//  5 Send 0x34,0x0C,0x07 then a 4th byte -> 4th byte NACKed; exactly one reg_wr (addr=6 data=0x007).
//  6 Assert rst during HI bit 4 -> sda_oe=0 in the same cycle. After release: busy=0, all regs at defaults.

Source files
------------

// File: rtl/wm8731_i2c_responder.sv
// wm8731_i2c_responder
//   Write-only I2C responder that models the WM8731 control port. It decodes
//   3-byte writes {dev_addr+W, reg[6:0]+data[8], data[7:0]}, ACKs them, and
//   updates a 9-bit x 10 register file (R0..R9). Writing register 15 restores
//   all register defaults.
//
// Optional build macro: I2C_RESP_ERR_CNT_EN enables the saturating 8-bit
//   protocol error counter on err_cnt. Without it, err_cnt is tied to zero.
//
// Ports
//   clk, rst       system clock; asynchronous active-high reset
//   scl_in/sda_in  asynchronous bus inputs (synchronized internally)
//   sda_oe         1 = pull SDA low (open-drain), 0 = release
//   reg_wr         one-clk pulse when a register write commits
//   reg_wr_addr    register address of the committed write (held)
//   reg_wr_data    9-bit data of the committed write (held)
//   rd_addr        combinational read select; rd_data = R[rd_addr], 0 if >9
//   codec_active   R9[0]
//   busy           high between START and STOP
//   err_cnt        protocol error count
//   state_dbg      current FSM state, for checkers
//
// Handshake: reg_wr is a single-cycle strobe with no back-pressure; addr and
// data are valid in the same cycle as the strobe and held until the next one.
module wm8731_i2c_responder #(
  parameter logic [6:0] DEV_ADDR    = 7'h1A,
  parameter int         SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr,
  output logic [6:0] reg_wr_addr,
  output logic [8:0] reg_wr_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       codec_active,
  output logic       busy,
  output logic [7:0] err_cnt,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ADDR   = 3'd1;
  localparam logic [2:0] S_ACK0   = 3'd2;
  localparam logic [2:0] S_HI     = 3'd3;
  localparam logic [2:0] S_ACK1   = 3'd4;
  localparam logic [2:0] S_LO     = 3'd5;
  localparam logic [2:0] S_ACK2   = 3'd6;
  localparam logic [2:0] S_IGNORE = 3'd7;

  function automatic logic [8:0] rf_default(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: rf_default = 9'h097;
      4'd2, 4'd3: rf_default = 9'h079;
      4'd4:       rf_default = 9'h00A;
      4'd5:       rf_default = 9'h008;
      4'd6:       rf_default = 9'h09F;
      4'd7:       rf_default = 9'h00A;
      default:    rf_default = 9'h000;
    endcase
  endfunction

  logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d, sda_sync_q, sda_sync_d;
  logic       scl_prev_q, scl_prev_d, sda_prev_q, sda_prev_d;
  logic [2:0] state_q, state_d;
  logic [3:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [6:0] addr_q, addr_d;
  logic       d8_q, d8_d;
  logic       sda_oe_q, sda_oe_d;
  logic       reg_wr_q, reg_wr_d;
  logic [6:0] reg_wr_addr_q, reg_wr_addr_d;
  logic [8:0] reg_wr_data_q, reg_wr_data_d;
  logic       busy_q, busy_d;
  logic [8:0] rf_q [10];
  logic [8:0] rf_d [10];
  logic       err_inc;

  logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det, partial_word;
  logic [8:0] wr_word;

  assign scl_s     = scl_sync_q[SYNC_STAGES-1];
  assign sda_s     = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = scl_s & ~scl_prev_q;
  assign scl_fall  = ~scl_s & scl_prev_q;
  assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
  assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
  // Address byte was ACKed but the data byte has not yet been fully sampled.
  assign partial_word = (state_q == S_HI) || (state_q == S_ACK1) ||
                        ((state_q == S_LO) && (bit_cnt_q != 4'd8));
  assign wr_word = {d8_q, shift_q[6:0], sda_s};

  always_comb begin
    scl_sync_d    = {scl_sync_q[SYNC_STAGES-2:0], scl_in};
    sda_sync_d    = {sda_sync_q[SYNC_STAGES-2:0], sda_in};
    scl_prev_d    = scl_s;
    sda_prev_d    = sda_s;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    addr_d        = addr_q;
    d8_d          = d8_q;
    sda_oe_d      = sda_oe_q;
    reg_wr_d      = 1'b0;
    reg_wr_addr_d = reg_wr_addr_q;
    reg_wr_data_d = reg_wr_data_q;
    busy_d        = busy_q;
    rf_d          = rf_q;
    err_inc       = 1'b0;

    if (start_det) begin
      state_d   = S_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
      busy_d    = 1'b1;
      err_inc   = partial_word;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
      err_inc  = partial_word;
    end else if (scl_rise) begin
      if (((state_q == S_ADDR) || (state_q == S_HI) || (state_q == S_LO)) &&
          (bit_cnt_q != 4'd8)) begin
        shift_d   = {shift_q[6:0], sda_s};
        bit_cnt_d = bit_cnt_q + 4'd1;
        // Last data bit: commit now so the strobe lands one clk later.
        if ((state_q == S_LO) && (bit_cnt_q == 4'd7)) begin
          if (addr_q <= 7'd9) begin
            rf_d[addr_q[3:0]] = wr_word;
            reg_wr_d          = 1'b1;
          end else if (addr_q == 7'd15) begin
            for (int i = 0; i < 10; i++) rf_d[i] = rf_default(4'(i));
            reg_wr_d = 1'b1;
          end else begin
            err_inc = 1'b1;
          end
          if (reg_wr_d) begin
            reg_wr_addr_d = addr_q;
            reg_wr_data_d = wr_word;
          end
        end
      end
    end else if (scl_fall) begin
      case (state_q)
        S_ADDR: if (bit_cnt_q == 4'd8) begin
          bit_cnt_d = 4'd0;
          if (shift_q == {DEV_ADDR, 1'b0}) begin
            sda_oe_d = 1'b1;
            state_d  = S_ACK0;
          end else begin
            state_d = S_IGNORE;
            err_inc = 1'b1;
          end
        end
        S_HI: if (bit_cnt_q == 4'd8) begin
          addr_d   = shift_q[7:1];
          d8_d     = shift_q[0];
          sda_oe_d = 1'b1;
          state_d  = S_ACK1;
        end
        S_LO: if (bit_cnt_q == 4'd8) begin
          sda_oe_d = 1'b1;
          state_d  = S_ACK2;
        end
        S_ACK0: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = S_HI;
        end
        S_ACK1: begin
          sda_oe_d  = 1'b0;
          bit_cnt_d = 4'd0;
          state_d   = S_LO;
        end
        S_ACK2: begin
          sda_oe_d = 1'b0;
          state_d  = S_IGNORE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q    <= '1;
      sda_sync_q    <= '1;
      scl_prev_q    <= 1'b1;
      sda_prev_q    <= 1'b1;
      state_q       <= S_IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'd0;
      addr_q        <= 7'd0;
      d8_q          <= 1'b0;
      sda_oe_q      <= 1'b0;
      reg_wr_q      <= 1'b0;
      reg_wr_addr_q <= 7'd0;
      reg_wr_data_q <= 9'd0;
      busy_q        <= 1'b0;
      for (int i = 0; i < 10; i++) rf_q[i] <= rf_default(4'(i));
    end else begin
      scl_sync_q    <= scl_sync_d;
      sda_sync_q    <= sda_sync_d;
      scl_prev_q    <= scl_prev_d;
      sda_prev_q    <= sda_prev_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      addr_q        <= addr_d;
      d8_q          <= d8_d;
      sda_oe_q      <= sda_oe_d;
      reg_wr_q      <= reg_wr_d;
      reg_wr_addr_q <= reg_wr_addr_d;
      reg_wr_data_q <= reg_wr_data_d;
      busy_q        <= busy_d;
      rf_q          <= rf_d;
    end
  end

`ifdef I2C_RESP_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end
  assign err_cnt = err_cnt_q;
`else
  logic unused_err_inc;
  assign unused_err_inc = err_inc;
  assign err_cnt        = 8'h00;
`endif

  assign sda_oe       = sda_oe_q;
  assign reg_wr       = reg_wr_q;
  assign reg_wr_addr  = reg_wr_addr_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign busy         = busy_q;
  assign rd_data      = (rd_addr <= 4'd9) ? rf_q[rd_addr] : 9'h000;
  assign codec_active = rf_q[9][0];
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_wm8731_i2c_responder.sv
// Testbench for wm8731_i2c_responder: an I2C master driver issues directed
// and random write transactions; a byte-level reference model predicts ACKs,
// register contents, error count and committed writes. Committed writes are
// queued and checked by an independent monitor on reg_wr.
module tb_wm8731_i2c_responder;
  localparam int Q = 5;  // clks per quarter SCL phase

  logic       clk = 1'b0;
  logic       rst;
  logic       scl_m, sda_m;
  logic       sda_oe, reg_wr, codec_active, busy;
  logic [6:0] reg_wr_addr;
  logic [8:0] reg_wr_data, rd_data;
  logic [3:0] rd_addr;
  logic [7:0] err_cnt;
  logic [2:0] state_dbg;
  wire        sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  wm8731_i2c_responder dut (
    .clk(clk), .rst(rst), .scl_in(scl_m), .sda_in(sda_line),
    .sda_oe(sda_oe), .reg_wr(reg_wr), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .rd_addr(rd_addr), .rd_data(rd_data),
    .codec_active(codec_active), .busy(busy), .err_cnt(err_cnt),
    .state_dbg(state_dbg)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Scoreboard entry: {compare_data, addr[6:0], data[8:0]}
  logic [16:0] exp_q[$];
  logic [8:0]  rf_def [10] = '{9'h097, 9'h097, 9'h079, 9'h079, 9'h00A,
                               9'h008, 9'h09F, 9'h00A, 9'h000, 9'h000};
  logic [8:0]  model_rf [10];
  int          model_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Monitor: every reg_wr strobe must match the oldest predicted write.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!rst && reg_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_reg_wr: got addr %0d data 0x%0h expected none", reg_wr_addr, reg_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("reg_wr_addr", 32'(reg_wr_addr), 32'(e[15:9]));
        if (e[16]) check("reg_wr_data", 32'(reg_wr_data), 32'(e[8:0]));
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(Q);
    sda_m = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2 * Q);
    scl_m = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output bit ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    ack = (sda_line == 1'b0);
    tick(Q);
    scl_m = 1'b0; tick(Q);
  endtask

  function automatic int sat_err(input int e);
    return (e > 255) ? 255 : e;
  endfunction

  task automatic check_err();
`ifdef I2C_RESP_ERR_CNT_EN
    check("err_cnt", 32'(err_cnt), 32'(sat_err(model_err)));
`else
    check("err_cnt_tied", 32'(err_cnt), 32'd0);
`endif
  endtask

  task automatic check_regs();
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      #1;
      check($sformatf("rd_data_r%0d", a), 32'(rd_data), (a <= 9) ? 32'(model_rf[a]) : 32'd0);
    end
    check("codec_active", 32'(codec_active), 32'(model_rf[9][0]));
  endtask

  // Predict the whole transaction from byte-level rules, then drive it.
  task automatic run_txn(input int n, input logic [7:0] b0, input logic [7:0] b1,
                         input logic [7:0] b2, input logic [7:0] b3, input bit do_stop);
    logic [7:0] b [4];
    bit         exp_ack [4];
    bit         ack;
    logic [6:0] a;
    b = '{b0, b1, b2, b3};
    for (int i = 0; i < 4; i++) exp_ack[i] = 1'b0;
    if (b0 == 8'h34) begin
      exp_ack[0] = 1'b1;
      if (n >= 2) exp_ack[1] = 1'b1;
      if (n >= 3) begin
        exp_ack[2] = 1'b1;
        a = b1[7:1];
        if (a <= 7'd9) begin
          model_rf[a] = {b1[0], b2};
          exp_q.push_back({1'b1, a, b1[0], b2});
        end else if (a == 7'd15) begin
          model_rf = rf_def;
          exp_q.push_back({1'b1, a, b1[0], b2});
        end else begin
          model_err++;
        end
      end else begin
        model_err++;
      end
    end else begin
      model_err++;
    end

    i2c_start();
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < n; i++) begin
      send_byte(b[i], ack);
      check($sformatf("ack_byte%0d", i), 32'(ack), 32'(exp_ack[i]));
    end
    if (do_stop) begin
      i2c_stop();
      check("busy_after_stop", 32'(busy), 32'd0);
      check_err();
    end
  endtask

  initial begin
    bit         ack;
    int         n, sel;
    logic [6:0] ra;
    logic [7:0] rb0;
    bit         rstop;

    rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1; rd_addr = 4'd0;
    model_rf = rf_def;
    tick(3);
    check("rst_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_reg_wr", 32'(reg_wr), 32'd0);
    check("rst_reg_wr_addr", 32'(reg_wr_addr), 32'd0);
    check("rst_reg_wr_data", 32'(reg_wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check_err();
    rst = 1'b0;
    tick(3);
    check_regs();

    // Directed scenarios
    run_txn(3, 8'h34, 8'h04, 8'h7F, 8'h00, 1'b1);   // R2 = 0x07F
    run_txn(3, 8'h36, 8'h04, 8'h7F, 8'h00, 1'b1);   // wrong address
    run_txn(3, 8'h34, 8'h12, 8'h01, 8'h00, 1'b1);   // R9 = 1
    check("codec_active_on", 32'(codec_active), 32'd1);
    run_txn(3, 8'h34, 8'h1E, 8'h00, 8'h00, 1'b1);   // reset register
    check("codec_active_off", 32'(codec_active), 32'd0);
    run_txn(2, 8'h34, 8'h0C, 8'h00, 8'h00, 1'b1);   // STOP before data
    run_txn(4, 8'h34, 8'h0C, 8'h07, 8'hA5, 1'b1);   // 4th byte NACKed
    run_txn(3, 8'h34, 8'h17, 8'h00, 8'h00, 1'b1);   // addr 11: out of range
    run_txn(3, 8'h34, 8'h13, 8'hFF, 8'h00, 1'b1);   // R9 = 0x1FF, d8 path
    check_regs();

    // Async reset during HI bit 4
    run_txn(3, 8'h34, 8'h09, 8'h55, 8'h00, 1'b1);   // R4 = 0x155
    i2c_start();
    send_byte(8'h34, ack);
    check("ack_before_rst", 32'(ack), 32'd1);
    for (int i = 0; i < 3; i++) send_bit(1'b0);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(Q);
    #2 rst = 1'b1;
    #1 check("rst_hi_sda_oe", 32'(sda_oe), 32'd0);
    check("rst_hi_busy", 32'(busy), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);
    model_rf = rf_def; model_err = 0;
    check("post_rst_busy", 32'(busy), 32'd0);
    check_regs();
    check_err();

    // Async reset while ACK is being driven: sda_oe must drop at once
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(1'(8'h34 >> i));
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2);
    check("ack_driven", 32'(sda_oe), 32'd1);
    #2 rst = 1'b1;
    #1 check("rst_ack_sda_oe", 32'(sda_oe), 32'd0);
    scl_m = 1'b1; sda_m = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(3);

    // Randomized traffic
    for (int t = 0; t < 30; t++) begin
      n   = $urandom_range(1, 4);
      rb0 = ($urandom_range(0, 3) != 0) ? 8'h34 : 8'($urandom_range(0, 255));
      sel = $urandom_range(0, 9);
      if (sel < 7)       ra = 7'($urandom_range(0, 9));
      else if (sel == 7) ra = 7'd15;
      else               ra = 7'($urandom_range(0, 127));
      rstop = ($urandom_range(0, 4) != 0);
      run_txn(n, rb0, {ra, 1'($urandom_range(0, 1))}, 8'($urandom), 8'($urandom), rstop);
      if (t % 10 == 9) check_regs();
    end
    run_txn(3, 8'h34, 8'h0A, 8'h3C, 8'h00, 1'b1);   // R5 = 0x03C, ends with STOP
    check_regs();
    tick(4);
    check("pending_writes", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
